// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: sequencer states and
// requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LD   = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of the unified MIPS memory: picks a winner,
// holds the access for MEM_LAT cycles, then returns registered read data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,

    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    input  logic          ld_lock,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int             CW       = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0]  LAT_LOAD = CW'(MEM_LAT);
    localparam logic [CW-1:0]  LAT_LAST = CW'(1);

    arb_state_e    state;
    logic [CW-1:0] cnt;
    logic          winner;
    logic          last_grant;
    logic          pick;

    // Pick is only consumed in IDLE; on a tie the lock overrides round-robin.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // can fall through and infer a latch.
        pick = PORT_CORE;
        if (core_req && ld_req) begin
            pick = ld_lock ? PORT_LD : ~last_grant;
        end else if (ld_req) begin
            pick = PORT_LD;
        end
    end

    assign core_stall = core_req & ~core_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            winner     <= PORT_CORE;
            last_grant <= PORT_LD;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_ack   <= 1'b0;
            ld_ack     <= 1'b0;
            core_rdata <= '0;
            ld_rdata   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            core_ack <= 1'b0;
            ld_ack   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (core_req || ld_req) begin
                        winner    <= pick;
                        mem_en    <= 1'b1;
                        mem_we    <= (pick == PORT_LD) ? ld_we    : core_we;
                        mem_addr  <= (pick == PORT_LD) ? ld_addr  : core_addr;
                        mem_wdata <= (pick == PORT_LD) ? ld_wdata : core_wdata;
                        cnt       <= LAT_LOAD;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == LAT_LAST) begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (winner == PORT_LD) begin
                            ld_rdata <= mem_rdata;
                            ld_ack   <= 1'b1;
                        end else begin
                            core_rdata <= mem_rdata;
                            core_ack   <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_grant <= winner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table on a MEM_LAT=1 instance plus
// hand-written write-latency and mid-access reset sequences on MEM_LAT=3.
module tb_mem_arbiter;

    localparam logic [31:0] A10 = 32'h0000_0010;
    localparam logic [31:0] A20 = 32'h0000_0020;
    localparam logic [31:0] A40 = 32'h0000_0040;
    localparam logic [31:0] D10 = 32'h8C01_0004;
    localparam logic [31:0] DBF = 32'hDEAD_BEEF;
    localparam logic [31:0] D40 = 32'h1234_5678;

    logic clk;
    logic reset_n;

    // MEM_LAT=1 instance
    logic        c1_req, c1_we, l1_req, l1_we, l1_lock;
    logic [31:0] c1_addr, c1_wdata, l1_addr, l1_wdata;
    logic        c1_ack, c1_stall, l1_ack;
    logic [31:0] c1_rdata, l1_rdata;
    logic        m1_en, m1_we;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [31:0] mem1 [0:63];

    // MEM_LAT=3 instance
    logic        c3_req, c3_we, l3_req, l3_we, l3_lock;
    logic [31:0] c3_addr, c3_wdata, l3_addr, l3_wdata;
    logic        c3_ack, c3_stall, l3_ack;
    logic [31:0] c3_rdata, l3_rdata;
    logic        m3_en, m3_we;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    logic [31:0] mem3 [0:63];

    int n_applied = 0;
    int n_miss    = 0;

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        lr, lw;
        logic [31:0] la, ld;
        logic        lk;
        logic        e_en, e_we;
        logic [31:0] e_addr;
        logic        e_cack, e_lack;
        logic        e_rdchk;
        logic [31:0] e_rd;
        logic        e_stall;
    } vec_t;

    vec_t vecs[$];

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .core_req(c1_req), .core_we(c1_we), .core_addr(c1_addr), .core_wdata(c1_wdata),
        .core_ack(c1_ack), .core_rdata(c1_rdata), .core_stall(c1_stall),
        .ld_req(l1_req), .ld_we(l1_we), .ld_addr(l1_addr), .ld_wdata(l1_wdata),
        .ld_ack(l1_ack), .ld_rdata(l1_rdata), .ld_lock(l1_lock),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .core_req(c3_req), .core_we(c3_we), .core_addr(c3_addr), .core_wdata(c3_wdata),
        .core_ack(c3_ack), .core_rdata(c3_rdata), .core_stall(c3_stall),
        .ld_req(l3_req), .ld_we(l3_we), .ld_addr(l3_addr), .ld_wdata(l3_wdata),
        .ld_ack(l3_ack), .ld_rdata(l3_rdata), .ld_lock(l3_lock),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory models with combinational read.
    assign m1_rdata = mem1[m1_addr[7:2]];
    assign m3_rdata = mem3[m3_addr[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem1[i] <= 32'h0;
        mem1[4] <= D10;
        forever begin
            @(posedge clk);
            if (m1_en && m1_we) mem1[m1_addr[7:2]] <= m1_wdata;
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) mem3[i] <= 32'h0;
        forever begin
            @(posedge clk);
            if (m3_en && m3_we) mem3[m3_addr[7:2]] <= m3_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic lr, input logic lw, input logic [31:0] la, input logic [31:0] ld,
                       input logic lk, input logic e_en, input logic e_we, input logic [31:0] e_addr,
                       input logic e_cack, input logic e_lack, input logic e_rdchk,
                       input logic [31:0] e_rd, input logic e_stall);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.lr = lr; v.lw = lw; v.la = la; v.ld = ld; v.lk = lk;
        v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr;
        v.e_cack = e_cack; v.e_lack = e_lack;
        v.e_rdchk = e_rdchk; v.e_rd = e_rd; v.e_stall = e_stall;
        vecs.push_back(v);
    endtask

    // Each row: inputs driven before an edge, outputs expected just after it.
    task automatic build_table();
        // Tie after reset: core first (read 0x10), then ld write 0x20.
        add(1,0,A10,0, 1,1,A20,DBF, 0,  1,0,A10, 0,0, 0,0,   1);
        add(1,0,A10,0, 1,1,A20,DBF, 0,  0,0,0,   1,0, 1,D10, 0);
        add(0,0,A10,0, 1,1,A20,DBF, 0,  0,0,0,   0,0, 0,0,   0);
        add(0,0,A10,0, 1,1,A20,DBF, 0,  1,1,A20, 0,0, 0,0,   0);
        add(0,0,A10,0, 1,1,A20,DBF, 0,  0,0,0,   0,1, 0,0,   0);
        add(0,0,A10,0, 0,0,A20,0,   0,  0,0,0,   0,0, 0,0,   0);
        // Core read of 0x10 alone.
        add(1,0,A10,0, 0,0,0,0,     0,  1,0,A10, 0,0, 0,0,   1);
        add(1,0,A10,0, 0,0,0,0,     0,  0,0,0,   1,0, 1,D10, 0);
        add(0,0,A10,0, 0,0,0,0,     0,  0,0,0,   0,0, 0,0,   0);
        // Loader read-back of the word it wrote.
        add(0,0,0,0,   1,0,A20,0,   0,  1,0,A20, 0,0, 0,0,   0);
        add(0,0,0,0,   1,0,A20,0,   0,  0,0,0,   0,1, 1,DBF, 0);
        add(0,0,0,0,   0,0,A20,0,   0,  0,0,0,   0,0, 0,0,   0);
        // Both held, no lock: core, ld, core, ld, core, ld.
        for (int k = 0; k < 6; k++) begin
            logic is_core;
            is_core = (k % 2 == 0);
            add(1,0,A10,0, 1,0,A20,0, 0,  1,0,(is_core ? A10 : A20), 0,0, 0,0, 1);
            add(1,0,A10,0, 1,0,A20,0, 0,  0,0,0, is_core, ~is_core, 1,
                (is_core ? D10 : DBF), ~is_core);
            add(1,0,A10,0, 1,0,A20,0, 0,  0,0,0, 0,0, 0,0, 1);
        end
        // Both held with lock: every grant to ld, core stays stalled.
        for (int k = 0; k < 4; k++) begin
            add(1,0,A10,0, 1,0,A20,0, 1,  1,0,A20, 0,0, 0,0,   1);
            add(1,0,A10,0, 1,0,A20,0, 1,  0,0,0,   0,1, 1,DBF, 1);
            add(1,0,A10,0, 1,0,A20,0, 1,  0,0,0,   0,0, 0,0,   1);
        end
        add(0,0,0,0, 0,0,0,0, 0,  0,0,0, 0,0, 0,0, 0);
    endtask

    task automatic run_latency3(input string tag, input logic is_write);
        @(posedge clk);
        for (int i = 1; i <= 6; i++) begin
            #1;
            check($sformatf("%s c%0d mem_en", tag, i), 32'(m3_en), 32'(i <= 3));
            check($sformatf("%s c%0d core_ack", tag, i), 32'(c3_ack), 32'(i == 4));
            if (i <= 3) begin
                check($sformatf("%s c%0d mem_we", tag, i), 32'(m3_we), 32'(is_write));
                check($sformatf("%s c%0d mem_addr", tag, i), m3_addr, A40);
                check($sformatf("%s c%0d stall", tag, i), 32'(c3_stall), 32'd1);
                if (is_write) check($sformatf("%s c%0d mem_wdata", tag, i), m3_wdata, D40);
            end
            if (i == 4) begin
                if (!is_write) check($sformatf("%s core_rdata", tag), c3_rdata, D40);
                check($sformatf("%s stall at ack", tag), 32'(c3_stall), 32'd0);
                c3_req = 1'b0;
            end
            check($sformatf("%s c%0d ld_ack", tag, i), 32'(l3_ack), 32'd0);
            @(posedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        l1_req = 1'b0; l1_we = 1'b0; l1_addr = '0; l1_wdata = '0; l1_lock = 1'b0;
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        l3_req = 1'b0; l3_we = 1'b0; l3_addr = '0; l3_wdata = '0; l3_lock = 1'b0;

        // Reset state; stall tracks core_req even in reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst mem_en", 32'(m1_en), 32'd0);
        check("rst mem_we", 32'(m1_we), 32'd0);
        check("rst mem_addr", m1_addr, 32'd0);
        check("rst mem_wdata", m1_wdata, 32'd0);
        check("rst core_ack", 32'(c1_ack), 32'd0);
        check("rst ld_ack", 32'(l1_ack), 32'd0);
        check("rst core_rdata", c1_rdata, 32'd0);
        check("rst ld_rdata", l1_rdata, 32'd0);
        check("rst core_stall", 32'(c1_stall), 32'd1);
        @(negedge clk);
        c1_req  = 1'b0;
        reset_n = 1'b1;

        build_table();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            c1_req = vecs[i].cr; c1_we = vecs[i].cw; c1_addr = vecs[i].ca; c1_wdata = vecs[i].cd;
            l1_req = vecs[i].lr; l1_we = vecs[i].lw; l1_addr = vecs[i].la; l1_wdata = vecs[i].ld;
            l1_lock = vecs[i].lk;
            @(posedge clk);
            #1;
            check($sformatf("v%0d mem_en", i), 32'(m1_en), 32'(vecs[i].e_en));
            check($sformatf("v%0d core_ack", i), 32'(c1_ack), 32'(vecs[i].e_cack));
            check($sformatf("v%0d ld_ack", i), 32'(l1_ack), 32'(vecs[i].e_lack));
            check($sformatf("v%0d core_stall", i), 32'(c1_stall), 32'(vecs[i].e_stall));
            if (vecs[i].e_en) begin
                check($sformatf("v%0d mem_we", i), 32'(m1_we), 32'(vecs[i].e_we));
                check($sformatf("v%0d mem_addr", i), m1_addr, vecs[i].e_addr);
            end
            if (vecs[i].e_rdchk && vecs[i].e_cack)
                check($sformatf("v%0d core_rdata", i), c1_rdata, vecs[i].e_rd);
            if (vecs[i].e_rdchk && vecs[i].e_lack)
                check($sformatf("v%0d ld_rdata", i), l1_rdata, vecs[i].e_rd);
        end
        check("mem1[0x20] after ld write", mem1[8], DBF);

        // MEM_LAT=3 core write: 3 strobe cycles, ack in the 4th.
        @(negedge clk);
        c3_req = 1'b1; c3_we = 1'b1; c3_addr = A40; c3_wdata = D40;
        run_latency3("lat3 wr", 1'b1);
        check("mem3[0x40] after core write", mem3[16], D40);

        // Reset during BUSY: immediate abort, no ack, then a clean retry.
        @(negedge clk);
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = A40; c3_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("abort pre mem_en", 32'(m3_en), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort async mem_en", 32'(m3_en), 32'd0);
        check("abort async core_ack", 32'(c3_ack), 32'd0);
        check("abort async core_rdata", c3_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort held mem_en", 32'(m3_en), 32'd0);
        check("abort held core_ack", 32'(c3_ack), 32'd0);
        check("abort held ld_rdata", l3_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_latency3("retry rd", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the single unified instruction/data memory of the multicycle MIPS core. Shares the memory between the core's fetch/load/store port (port 0) and the program-loader/debug port (port 1) through a req/ack handshake. Sequences each access through a fixed memory latency and returns registered read data. Sits between the core datapath's memory mux and the memory model.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles mem_en is held per access, ≥1; memory read data valid on the last held cycle

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- core_req  in  1  core access request, held until core_ack
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  byte address
- core_wdata  in  DW  write data
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  DW  read data, valid while core_ack
- core_stall  out  1  core_req & ~core_ack, combinational; drives core PCWrite/IRWrite gating
- ld_req, ld_we, ld_addr, ld_wdata, ld_ack, ld_rdata  same as core_* for port 1
- ld_lock  in  1  while high, port 1 wins every tie
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, only meaningful with mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any req, choose winner, latch its we/addr/wdata into registers, load counter with MEM_LAT, go BUSY. No req: stay IDLE.
- Winner: only one req → that port. Both → ld_lock ? port 1 : port that did not win last grant (round-robin). last_grant resets to port 1, so core wins the first tie.
- BUSY: mem_en=1, mem_we/addr/wdata from latched registers; counter decrements each cycle; on the cycle counter==1, capture mem_rdata into rdata register, go DONE.
- DONE: ack of winning port = 1 for exactly this cycle; that port's rdata = captured value (writes: rdata holds capture, don't care); update last_grant; go IDLE.
- Non-winning port's req is ignored until IDLE; it is never dropped.
- Requester lowering req mid-access is illegal; arbiter still completes the access and pulses ack.
- Outputs at reset: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, core_ack=0, ld_ack=0, core_rdata=0, ld_rdata=0; state IDLE; counter 0; last_grant=port 1. core_stall follows core_req.
- Reset mid-access: all of the above take effect asynchronously; aborted access is not acked; requester must re-request.
- Counter width $clog2(MEM_LAT+1); no wrap (reloaded only in IDLE).

## Timing
- req first sampled high in IDLE at edge E0 → BUSY for cycles E0..E0+MEM_LAT → ack high in the cycle after edge E0+MEM_LAT. Request-to-ack: MEM_LAT+1 cycles after the sampling edge.
- mem_en high for exactly MEM_LAT consecutive cycles per access; low in IDLE and DONE.
- Back-to-back: a request pending during DONE is sampled at the next IDLE edge; minimum period MEM_LAT+2 cycles per access.
- All outputs except core_stall registered.

## Structure
- Shared package mem_arb_pkg: state encoding (IDLE/BUSY/DONE), port index constants PORT_CORE=0, PORT_LD=1.
- Single module; round-robin pick and latency counter inline, no sub-module.

## Test plan
- Core read alone, MEM_LAT=1, addr 0x0000_0010, memory returns 0x8C01_0004 → mem_en one cycle, core_ack 2 cycles after sampling edge, core_rdata=0x8C01_0004, ld_ack stays 0.
- Simultaneous core read and ld write after reset → core served first, ld write (addr 0x20, data 0xDEAD_BEEF) next; memory at 0x20 holds 0xDEAD_BEEF; acks never overlap.
- Both req held continuously for 6 accesses, ld_lock=0 → grants alternate core, ld, core, ld, core, ld.
- ld_lock=1, both req held for 4 accesses → all 4 grants to ld; core_stall stays 1 throughout.
- MEM_LAT=3 core write → mem_en high exactly 3 cycles with stable addr/wdata; core_ack 4 cycles after sampling edge.
- reset_n pulsed low during BUSY → mem_en and all acks 0 immediately, no ack for aborted access; after release, re-requested access completes normally.
